// File: rtl/opponent_state_decoder.sv
// opponent_state_decoder
// Validates opponent packet words from the Ethernet receive stage. It drops
// duplicates and out-of-range words, and holds the last good opponent state as
// registered fields. It also produces link status, a one-shot opponent-reset
// pulse and packet statistics.
//
// Ports:
//   clk_in           eth_refclk (50 MHz)
//   rst_in           synchronous active-high reset
//   axiov / axiod    packet word strobe / 44-bit packet word
//   opp_x, opp_y     last accepted coordinates (11 bits each)
//   opp_dir          last accepted direction (9 bits)
//   opp_game         last accepted game status (3 bits)
//   opp_reset_pulse  one-cycle pulse on a 0->1 edge of the accepted rst flag
//   new_pkt          one-cycle pulse when the field outputs update
//   link_up          high while accepted packets keep arriving within the timeout
//   pkt_count        accepted packets, wrapping
//   err_count        rejected packets, saturating at 255
//
// Optional build macro: SEQ_CHECK_EN. When it is defined, the block checks
// sequence continuity on accepted packets and counts breaks in err_count.
module opponent_state_decoder #(
  parameter int MAX_COORD      = 1024,
  parameter int MAX_DIR        = 360,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        axiov,
  input  logic [43:0] axiod,
  output logic [10:0] opp_x,
  output logic [10:0] opp_y,
  output logic [8:0]  opp_dir,
  output logic [2:0]  opp_game,
  output logic        opp_reset_pulse,
  output logic        new_pkt,
  output logic        link_up,
  output logic [15:0] pkt_count,
  output logic [7:0]  err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LP_TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] LP_TMO_ONE   = TW'(1);
  localparam logic [10:0]   LP_MAX_COORD = 11'(MAX_COORD);
  localparam logic [8:0]    LP_MAX_DIR   = 9'(MAX_DIR);

  typedef enum logic [0:0] {
    LINK_DOWN = 1'b0,
    LINK_UP   = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [43:0]   r_last_word;
  logic          r_last_rst_flag;
  logic [TW-1:0] r_tmo;
  logic [10:0]   r_opp_x;
  logic [10:0]   r_opp_y;
  logic [8:0]    r_opp_dir;
  logic [2:0]    r_opp_game;
  logic          r_reset_pulse;
  logic          r_new_pkt;
  logic [15:0]   r_pkt_count;
  logic [7:0]    r_err_count;

  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [8:0]  w_dir;
  logic [2:0]  w_game;
  logic        w_rst_flag;
  logic        w_fresh;
  logic        w_fields_ok;
  logic        w_accept;
  logic        w_reject;
  logic        w_expire;
  logic        w_seq_err;

  assign w_x        = axiod[43:33];
  assign w_y        = axiod[31:21];
  assign w_dir      = axiod[19:11];
  assign w_game     = axiod[7:5];
  assign w_rst_flag = axiod[3];

  // The duplicate filter compares the whole word, so reserved bits count too.
  assign w_fresh     = axiov && (axiod != 44'd0) && (axiod != r_last_word);
  assign w_fields_ok = (w_x < LP_MAX_COORD) && (w_y < LP_MAX_COORD) && (w_dir < LP_MAX_DIR);
  assign w_accept    = w_fresh && w_fields_ok;
  assign w_reject    = w_fresh && !w_fields_ok;
  // An accept in the expiry cycle takes priority over the timeout.
  assign w_expire    = (r_state == LINK_UP) && !w_accept && (r_tmo == LP_TMO_LAST);

`ifdef SEQ_CHECK_EN
  logic [2:0] w_seq;
  logic [2:0] r_last_seq;

  assign w_seq = axiod[10:8];
  // The first packet after LINK_DOWN starts a new sequence and is not checked.
  assign w_seq_err = w_accept && (r_state == LINK_UP) && (w_seq != (r_last_seq + 3'd1));

  // Last accepted sequence number; cleared on reset and on link loss.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_last_seq <= 3'd0;
    end else if (w_accept) begin
      r_last_seq <= w_seq;
    end else if (w_expire) begin
      r_last_seq <= 3'd0;
    end else begin
      r_last_seq <= r_last_seq;
    end
  end
`else
  assign w_seq_err = 1'b0;
`endif

  // Link state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= LINK_DOWN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LINK_DOWN: w_next_state = w_accept ? LINK_UP : LINK_DOWN;
      LINK_UP:   w_next_state = w_expire ? LINK_DOWN : LINK_UP;
      default:   w_next_state = LINK_DOWN;
    endcase
  end

  // State-decoded output. It is a decode of the state register only, so it is glitch-free.
  always_comb begin
    link_up = 1'b0;
    case (r_state)
      LINK_UP:   link_up = 1'b1;
      LINK_DOWN: link_up = 1'b0;
      default:   link_up = 1'b0;
    endcase
  end

  // Field registers, pulses, packet counter, duplicate history and timeout counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_opp_x         <= 11'd0;
      r_opp_y         <= 11'd0;
      r_opp_dir       <= 9'd0;
      r_opp_game      <= 3'd0;
      r_reset_pulse   <= 1'b0;
      r_new_pkt       <= 1'b0;
      r_pkt_count     <= 16'd0;
      r_last_word     <= 44'd0;
      r_last_rst_flag <= 1'b0;
      r_tmo           <= '0;
    end else begin
      r_new_pkt     <= w_accept;
      r_reset_pulse <= w_accept && w_rst_flag && !r_last_rst_flag;
      if (w_accept) begin
        r_opp_x         <= w_x;
        r_opp_y         <= w_y;
        r_opp_dir       <= w_dir;
        r_opp_game      <= w_game;
        r_pkt_count     <= r_pkt_count + 16'd1;
        r_last_word     <= axiod;
        r_last_rst_flag <= w_rst_flag;
        r_tmo           <= '0;
      end else if (w_expire) begin
        // Forgetting history lets an identical retransmit through after reconnect.
        r_last_word     <= 44'd0;
        r_last_rst_flag <= 1'b0;
        r_tmo           <= '0;
      end else if ((r_state == LINK_UP) || (r_tmo != LP_TMO_LAST)) begin
        // Counts while up; while down it only creeps up to the limit and stays there.
        r_tmo <= r_tmo + LP_TMO_ONE;
      end else begin
        r_tmo <= r_tmo;
      end
    end
  end

  // Saturating error counter covering range rejects and, optionally, sequence breaks.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_err_count <= 8'd0;
    end else if ((w_reject || w_seq_err) && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign opp_x           = r_opp_x;
  assign opp_y           = r_opp_y;
  assign opp_dir         = r_opp_dir;
  assign opp_game        = r_opp_game;
  assign opp_reset_pulse = r_reset_pulse;
  assign new_pkt         = r_new_pkt;
  assign pkt_count       = r_pkt_count;
  assign err_count       = r_err_count;

endmodule

// File: tb/tb_opponent_state_decoder.sv
// Testbench for opponent_state_decoder. It drives directed scenarios and then
// random traffic. After every clock it compares all outputs against a
// packet-level reference model.
module tb_opponent_state_decoder;

  localparam int TO   = 100;
  localparam int MAXC = 1024;
  localparam int MAXD = 360;

  logic        clk;
  logic        rst_in;
  logic        axiov;
  logic [43:0] axiod;
  logic [10:0] opp_x;
  logic [10:0] opp_y;
  logic [8:0]  opp_dir;
  logic [2:0]  opp_game;
  logic        opp_reset_pulse;
  logic        new_pkt;
  logic        link_up;
  logic [15:0] pkt_count;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          m_x, m_y, m_dir, m_game, m_pulse, m_new, m_up, m_pkt, m_err;
  int          m_since, m_last_rst, m_last_seq;
  logic [43:0] m_last_word;

  opponent_state_decoder #(.MAX_COORD(MAXC), .MAX_DIR(MAXD), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk), .rst_in(rst_in), .axiov(axiov), .axiod(axiod),
    .opp_x(opp_x), .opp_y(opp_y), .opp_dir(opp_dir), .opp_game(opp_game),
    .opp_reset_pulse(opp_reset_pulse), .new_pkt(new_pkt), .link_up(link_up),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [43:0] mk(input int x, input int y, input int dir,
                                     input int seq, input int game, input int rf);
    logic [43:0] w;
    w = 44'd0;
    w[43:33] = x[10:0];
    w[31:21] = y[10:0];
    w[19:11] = dir[8:0];
    w[10:8]  = seq[2:0];
    w[7:5]   = game[2:0];
    w[3]     = rf[0];
    return w;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dir = 0; m_game = 0; m_pulse = 0; m_new = 0; m_up = 0;
    m_pkt = 0; m_err = 0; m_since = 0; m_last_rst = 0; m_last_seq = 0;
    m_last_word = 44'd0;
  endtask

  task automatic model_step(input logic r, input logic v, input logic [43:0] d);
    logic fresh, ok;
    if (r) begin
      model_reset();
    end else begin
      fresh = v && (d != 44'd0) && (d != m_last_word);
      ok = (int'(d[43:33]) < MAXC) && (int'(d[31:21]) < MAXC) && (int'(d[19:11]) < MAXD);
      m_new = 0;
      m_pulse = 0;
      if (fresh && ok) begin
`ifdef SEQ_CHECK_EN
        if (m_up == 1 && int'(d[10:8]) != (m_last_seq + 1) % 8 && m_err < 255) m_err++;
        m_last_seq = int'(d[10:8]);
`endif
        m_x = int'(d[43:33]); m_y = int'(d[31:21]); m_dir = int'(d[19:11]); m_game = int'(d[7:5]);
        m_new = 1;
        m_pulse = (d[3] && m_last_rst == 0) ? 1 : 0;
        m_last_rst = int'(d[3]);
        m_pkt = (m_pkt + 1) % 65536;
        m_last_word = d;
        m_since = 0;
        m_up = 1;
      end else begin
        if (fresh && m_err < 255) m_err++;
        if (m_up == 1) begin
          m_since++;
          if (m_since == TO) begin
            m_up = 0; m_since = 0; m_last_word = 44'd0; m_last_rst = 0; m_last_seq = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("opp_x", opp_x, m_x);
    check("opp_y", opp_y, m_y);
    check("opp_dir", opp_dir, m_dir);
    check("opp_game", opp_game, m_game);
    check("opp_reset_pulse", opp_reset_pulse, m_pulse);
    check("new_pkt", new_pkt, m_new);
    check("link_up", link_up, m_up);
    check("pkt_count", pkt_count, m_pkt);
    check("err_count", err_count, m_err);
  endtask

  // One clock: drive inputs, step the model at the edge, compare 1 time unit later.
  task automatic tick(input logic r, input logic v, input logic [43:0] d);
    rst_in = r; axiov = v; axiod = d;
    @(posedge clk);
    model_step(r, v, d);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 44'd0);
  endtask

  logic [43:0] w1, w5, w6, wr;
  int kind;

  initial begin
    rst_in = 1'b1; axiov = 1'b0; axiod = 44'd0;
    model_reset();
    tick(1'b1, 1'b0, 44'd0);
    tick(1'b1, 1'b0, 44'd0);
    check("rst_link_up", link_up, 0);
    check("rst_pkt_count", pkt_count, 0);

    // first valid word
    w1 = mk(191, 191, 270, 0, 1, 0);
    tick(1'b0, 1'b1, w1);
    check("w1_x", opp_x, 191);
    check("w1_y", opp_y, 191);
    check("w1_dir", opp_dir, 270);
    check("w1_game", opp_game, 1);
    check("w1_new", new_pkt, 1);
    check("w1_link", link_up, 1);
    check("w1_pkt", pkt_count, 1);

    // duplicates
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, w1);
    check("dup_pkt", pkt_count, 1);
    check("dup_err", err_count, 0);
    check("dup_new", new_pkt, 0);

    // range rejects
    tick(1'b0, 1'b1, mk(5, 5, 400, 1, 1, 0));
    tick(1'b0, 1'b1, mk(1100, 5, 10, 1, 1, 0));
    check("rej_err", err_count, 2);
    check("rej_x", opp_x, 191);
    check("rej_new", new_pkt, 0);

    // rst flag edge
    tick(1'b0, 1'b1, mk(10, 20, 30, 1, 2, 0));
    check("rf0_pulse", opp_reset_pulse, 0);
    tick(1'b0, 1'b1, mk(11, 21, 31, 2, 2, 1));
    check("rf1_pulse", opp_reset_pulse, 1);
    idle(1);
    check("rf1_pulse_end", opp_reset_pulse, 0);
    tick(1'b0, 1'b1, mk(12, 22, 32, 3, 2, 1));
    check("rf11_pulse", opp_reset_pulse, 0);

    // timeout: link falls exactly TO cycles after new_pkt
    w5 = mk(100, 200, 300, 4, 3, 0);
    tick(1'b0, 1'b1, w5);
    idle(TO - 1);
    check("tmo_still_up", link_up, 1);
    idle(1);
    check("tmo_down", link_up, 0);
    tick(1'b0, 1'b1, w5);
    check("reconnect_new", new_pkt, 1);
    check("reconnect_link", link_up, 1);

    // accept on the expiry cycle keeps the link up
    idle(TO - 1);
    w6 = mk(101, 201, 301, 5, 3, 0);
    tick(1'b0, 1'b1, w6);
    check("expiry_accept_link", link_up, 1);
    idle(1);
    check("expiry_after_link", link_up, 1);

    // sequence continuity 0,1,3 from a fresh reset
    tick(1'b1, 1'b0, 44'd0);
    tick(1'b0, 1'b1, mk(1, 1, 1, 0, 0, 0));
    tick(1'b0, 1'b1, mk(2, 2, 2, 1, 0, 0));
    tick(1'b0, 1'b1, mk(3, 3, 3, 3, 0, 0));
    check("seq_pkt", pkt_count, 3);
`ifdef SEQ_CHECK_EN
    check("seq_err", err_count, 1);
`else
    check("seq_err", err_count, 0);
`endif

    // reset during a strobe
    tick(1'b1, 1'b1, mk(7, 7, 7, 4, 1, 1));
    check("rst_strobe_x", opp_x, 0);
    check("rst_strobe_new", new_pkt, 0);
    check("rst_strobe_link", link_up, 0);
    check("rst_strobe_pkt", pkt_count, 0);

    // random traffic
    for (int it = 0; it < 1500; it++) begin
      kind = int'($urandom_range(0, 19));
      if (kind == 0) begin
        tick(1'b1, $urandom_range(0, 1) == 1, mk(9, 9, 9, 0, 0, 0));
      end else if (kind == 1) begin
        idle(int'($urandom_range(90, 110)));
      end else if (kind <= 4) begin
        idle(1);
      end else if (kind == 5) begin
        tick(1'b0, 1'b1, 44'd0);
      end else if (kind == 6) begin
        tick(1'b0, 1'b1, m_last_word);
      end else if (kind == 7) begin
        wr = mk(int'($urandom_range(MAXC, 2047)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 359)), int'($urandom_range(0, 7)), 1, 0);
        tick(1'b0, 1'b1, wr);
      end else if (kind == 8) begin
        wr = mk(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                int'($urandom_range(MAXD, 511)), int'($urandom_range(0, 7)), 1, 0);
        tick(1'b0, 1'b1, wr);
      end else begin
        wr = mk(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 359)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : (m_last_seq + 1) % 8,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
        wr[32]  = 1'($urandom_range(0, 1));
        wr[20]  = 1'($urandom_range(0, 1));
        wr[4]   = 1'($urandom_range(0, 1));
        wr[2:0] = 3'($urandom_range(0, 7));
        tick(1'b0, 1'b1, wr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/opponent_state_decoder.md
Name: opponent_state_decoder

Overview:
- Sits directly downstream of the Ethernet `receive` stage on the 50 MHz `eth_refclk` domain.
- Consumes each 44-bit opponent packet word (`axiov`/`axiod`), validates it and drops duplicates.
- Holds the last good opponent state as stable registered fields for `track_view`, `racer_view` and `forward_view`.
- Generates link-status, one-shot opponent-reset and packet-statistics signals for the top level.

Parameters:
- MAX_COORD, 1024, exclusive upper bound for x and y; fields >= MAX_COORD are rejected.
- MAX_DIR, 360, exclusive upper bound for direction in degrees.
- TIMEOUT_CYCLES, 5000000, cycles without an accepted packet before the link is declared down (100 ms at 50 MHz).

Ports:
- clk_in  input  1  `eth_refclk`, 50 MHz.
- rst_in  input  1  synchronous, active-high reset.
- axiov  input  1  packet word valid, single-cycle strobe from `receive`.
- axiod  input  44  packet word. Fields:
  - x = [43:33]
  - y = [31:21]
  - dir = [19:11]
  - seq = [10:8]
  - game = [7:5]
  - rst flag = [3]
  - bits [32], [20], [4], [2:0] reserved.
- opp_x  output  11  last accepted x.
- opp_y  output  11  last accepted y.
- opp_dir  output  9  last accepted direction.
- opp_game  output  3  last accepted game status.
- opp_reset_pulse  output  1  one-cycle pulse on a 0->1 transition of the accepted rst flag.
- new_pkt  output  1  one-cycle pulse when the outputs update.
- link_up  output  1  high while packets keep arriving within the timeout.
- pkt_count  output  16  accepted packets, wraps.
- err_count  output  8  rejected packets, saturates at 255.

Behaviour:
- Reset values:
  - opp_x = 0, opp_y = 0, opp_dir = 0, opp_game = 0.
  - opp_reset_pulse = 0, new_pkt = 0, link_up = 0.
  - pkt_count = 0, err_count = 0.
  - Internal last_word = 0, last_rst_flag = 0, timeout counter = 0, state = LINK_DOWN.
- A reset asserted mid-operation overrides every other event in that cycle.
- Acceptance is evaluated only when axiov = 1. A word is:
  - Ignored (no counters change) if axiod == 0 or axiod == last_word. This is the duplicate filter.
  - Rejected if x >= MAX_COORD, y >= MAX_COORD, or dir >= MAX_DIR. Rejection increments err_count (saturating) and changes nothing else; last_word is not updated.
  - Otherwise accepted.
- On an accepted word:
  - Latency: the field outputs are registered 1 cycle after the axiov cycle.
  - new_pkt = 1 for that same cycle.
  - pkt_count increments, wrapping 65535 -> 0.
  - last_word <= axiod.
  - The timeout counter clears.
  - opp_reset_pulse = 1 for one cycle if rst flag = 1 and last_rst_flag = 0; last_rst_flag <= rst flag.
- Reserved bits are ignored, but they still count toward the duplicate comparison.
- State machine:
  - LINK_DOWN: link_up = 0. An accepted packet moves to LINK_UP in the next cycle; link_up rises together with new_pkt.
  - LINK_UP: link_up = 1. The timeout counter increments each cycle with no accepted packet. When it reaches TIMEOUT_CYCLES-1, go to LINK_DOWN and clear the counter.
- On entering LINK_DOWN:
  - Field outputs hold their last values.
  - last_word and last_rst_flag clear, so an identical retransmit after reconnect is accepted.
- Simultaneous events:
  - Accepted packet in the cycle the timeout would expire: the packet wins, the counter clears and the state stays LINK_UP.
  - The timeout counter saturates while in LINK_DOWN (no wrap).
- Widths: timeout counter is $clog2(TIMEOUT_CYCLES) bits. Comparisons are unsigned at field width.

Optional Feature:
- Macro: SEQ_CHECK_EN.
- When defined:
  - On each accepted packet other than the first after LINK_DOWN, compare seq against (last_seq+1) mod 8.
  - On a mismatch, err_count increments (saturating) and the packet is still accepted.
  - last_seq updates on every accepted packet and clears on reset and on LINK_DOWN.
- When not defined: seq is ignored apart from the duplicate comparison; no seq registers are built.

Test Plan:
- Reset, then a single valid word x=191, y=191, dir=270, game=1, seq=0, rst=0:
  - 1 cycle later: opp_x = 191, opp_y = 191, opp_dir = 270, opp_game = 1.
  - new_pkt and link_up rise; pkt_count = 1.
- Same word strobed 5 more times:
  - No new_pkt; pkt_count stays 1; err_count stays 0.
- Word with dir=400, then a word with x=1100:
  - err_count = 2; outputs unchanged; no new_pkt.
- Two accepted words with rst flag 0 then 1, then a third distinct word with rst flag 1:
  - opp_reset_pulse high for exactly 1 cycle, after the second word only.
- TIMEOUT_CYCLES = 100, no packets after one accept:
  - link_up falls exactly 100 cycles after the new_pkt cycle.
  - Re-sending the original word afterwards is accepted and link_up rises.
  - Separately, an accept arriving on the expiry cycle keeps link_up = 1.
- With SEQ_CHECK_EN, seq sequence 0, 1, 3 on distinct valid words:
  - err_count = 1; pkt_count = 3.
- Reset asserted during a packet strobe:
  - All outputs are 0 on the next cycle.
